// File: rtl/step_pulse_gen.sv
// step_pulse_gen: step/direction pulse generator with a direction setup delay, abort and a signed position counter.
module step_pulse_gen #(
  parameter int HIGH_CYCLES  = 50,
  parameter int LOW_CYCLES   = 50,
  parameter int SETUP_CYCLES = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dir_in,
  input  logic [7:0]  val_in,
  input  logic        done_in,
  input  logic        abort,
  output logic        ready,
  output logic        step,
  output logic        dir,
  output logic [15:0] position
);
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;
  state_t      r_state, w_nstate;
  logic [31:0] r_cnt, w_cnt;
  logic [7:0]  r_rem, w_rem;
  logic        r_ready, r_step, r_dir;
  logic [15:0] r_pos, w_pos;
  logic        w_go, w_end, w_dir, w_rise;
  assign ready    = r_ready;
  assign step     = r_step;
  assign dir      = r_dir;
  assign position = r_pos;
  assign w_go  = r_state == IDLE && r_ready && done_in && !abort && val_in != 8'd0;
  assign w_end = r_cnt == (r_state == SETUP ? 32'(SETUP_CYCLES - 1) :
                           r_state == HIGH  ? 32'(HIGH_CYCLES - 1)  : 32'(LOW_CYCLES - 1));
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_ready <= 1'b1;
      r_step  <= 1'b0;
      r_dir   <= 1'b0;
      r_pos   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_cnt;
      r_rem   <= w_rem;
      r_ready <= w_nstate == IDLE;
      r_step  <= w_nstate == HIGH;
      r_dir   <= w_dir;
      r_pos   <= w_pos;
    end
  end
  always_comb begin
    w_nstate = r_state;
    if (abort) w_nstate = IDLE;
    else case (r_state)
      IDLE:    if (w_go) w_nstate = dir_in != r_dir ? SETUP : HIGH;
      SETUP:   if (w_end) w_nstate = HIGH;
      HIGH:    if (w_end) w_nstate = LOW;
      LOW:     if (w_end) w_nstate = r_rem != 8'd0 ? HIGH : IDLE;
      default: w_nstate = IDLE;
    endcase
  end
  // position moves on the edge that raises step, using the direction being driven on that edge
  always_comb begin
    w_dir  = w_go ? dir_in : r_dir;
    w_rise = w_nstate == HIGH && r_state != HIGH;
    w_pos  = w_rise ? r_pos + (w_dir ? 16'd1 : 16'hFFFF) : r_pos;
    w_rem  = abort ? 8'd0 : w_go ? val_in : (r_state == HIGH && w_end) ? r_rem - 8'd1 : r_rem;
    w_cnt  = (w_nstate != r_state || r_state == IDLE) ? 32'd0 : r_cnt + 32'd1;
  end
endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: scoreboard bench; commands push expected completions, a monitor measures pulses and compares on ready rising.
module tb_step_pulse_gen;
  localparam int H = 2, L = 3, S = 4;
  logic        clk = 1'b0;
  logic        rst, dir_in, done_in, abort, ready, step, dir;
  logic [7:0]  val_in;
  logic [15:0] position;
  logic        rst2, dir2i, done2, ready2, step2, dir2;
  logic [7:0]  val2;
  logic [15:0] pos2;
  int n_chk = 0, n_pass = 0;
  typedef struct {logic [15:0] pos; logic dir; int pulses; int busy; int lead;} exp_t;
  exp_t sb[$];
  int busy = 0, pulses = 0, lead = 0, hrun = 0, lrun = 0;
  logic prev_ready = 1'b1, prev_step = 1'b0;

  always #5 clk = ~clk;

  step_pulse_gen #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .SETUP_CYCLES(S)) dut (
    .clock(clk), .reset(rst), .dir_in(dir_in), .val_in(val_in), .done_in(done_in),
    .abort(abort), .ready(ready), .step(step), .dir(dir), .position(position));

  // fast-timed copy so the 0x7FFF wrap point is reachable in a short run
  step_pulse_gen #(.HIGH_CYCLES(1), .LOW_CYCLES(1), .SETUP_CYCLES(1)) dut2 (
    .clock(clk), .reset(rst2), .dir_in(dir2i), .val_in(val2), .done_in(done2),
    .abort(1'b0), .ready(ready2), .step(step2), .dir(dir2), .position(pos2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!ready) begin
      busy++;
      if (step) begin
        if (!prev_step) begin
          if (pulses > 0) chk("low_width", lrun, L);
          pulses++;
          hrun = 0;
        end
        hrun++;
      end else begin
        if (prev_step) begin
          chk("high_width", hrun, H);
          lrun = 0;
        end
        if (pulses == 0) lead++;
        else lrun++;
      end
    end else if (!prev_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_completion: got position %0h expected no completion", position);
      end else begin
        e = sb.pop_front();
        chk("done_position", position, e.pos);
        chk("done_dir", dir, e.dir);
        chk("done_pulses", pulses, e.pulses);
        chk("done_busy", busy, e.busy);
        chk("done_setup", lead, e.lead);
      end
      busy = 0; pulses = 0; lead = 0; hrun = 0; lrun = 0;
    end
    prev_ready = ready;
    prev_step  = step;
  end

  task automatic issue(input logic d, input logic [7:0] v);
    dir_in = d; val_in = v; done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
    if (!ready) begin
      n_chk++;
      $display("FAIL ready_timeout: got ready 0 expected 1");
    end
    @(negedge clk);
  endtask

  task automatic run2(input logic [7:0] v);
    dir2i = 1'b1; val2 = v; done2 = 1'b1;
    @(negedge clk);
    done2 = 1'b0;
    for (int i = 0; i < 600 && !ready2; i++) @(negedge clk);
    if (!ready2) begin
      n_chk++;
      $display("FAIL ready2_timeout: got ready 0 expected 1");
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; dir_in = 1'b0; val_in = 8'd0; done_in = 1'b0; abort = 1'b0;
    rst2 = 1'b1; dir2i = 1'b0; val2 = 8'd0; done2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_step", step, 0);
    chk("reset_dir", dir, 0);
    chk("reset_position", position, 16'h0000);
    rst = 1'b0;
    sb.push_back('{16'hFFFD, 1'b0, 3, 15, 0});
    issue(1'b0, 8'd3);
    wait_idle();
    sb.push_back('{16'hFFFF, 1'b1, 2, 14, 4});
    issue(1'b1, 8'd2);
    chk("dir_immediate", dir, 1);
    chk("setup_step_low", step, 0);
    wait_idle();
    issue(1'b0, 8'd0);
    chk("zero_ready", ready, 1);
    chk("zero_dir", dir, 1);
    chk("zero_position", position, 16'hFFFF);
    repeat (3) @(negedge clk);
    chk("zero_no_step", step, 0);
    for (int k = 0; k < 5; k++) sb.push_back('{16'(k), 1'b1, 1, 5, 0});
    dir_in = 1'b1; val_in = 8'd1; done_in = 1'b1;
    repeat (30) @(negedge clk);
    done_in = 1'b0;
    wait_idle();
    sb.push_back('{16'h0006, 1'b1, 2, 6, 0});
    issue(1'b1, 8'd5);
    repeat (5) @(negedge clk);
    chk("second_high", step, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_step", step, 0);
    chk("abort_ready", ready, 1);
    chk("abort_position", position, 16'h0006);
    repeat (20) @(negedge clk);
    chk("abort_no_more", position, 16'h0006);
    dir_in = 1'b0; val_in = 8'd3; done_in = 1'b1; abort = 1'b1;
    @(negedge clk);
    done_in = 1'b0; abort = 1'b0;
    chk("abort_wins_ready", ready, 1);
    chk("abort_wins_dir", dir, 1);
    repeat (3) @(negedge clk);
    chk("abort_wins_idle", ready, 1);
    chk("abort_wins_position", position, 16'h0006);
    rst2 = 1'b0;
    for (int k = 0; k < 128; k++) run2(8'd255);
    run2(8'd127);
    chk("reach_7fff", pos2, 16'h7FFF);
    run2(8'd2);
    chk("wrap_8001", pos2, 16'h8001);
    dir2i = 1'b1; val2 = 8'd2; done2 = 1'b1;
    @(negedge clk);
    done2 = 1'b0;
    chk("mid_pulse_step", step2, 1);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    chk("midreset_step", step2, 0);
    chk("midreset_ready", ready2, 1);
    chk("midreset_dir", dir2, 0);
    chk("midreset_position", pos2, 16'h0000);
    repeat (10) @(negedge clk);
    chk("midreset_no_pulse", pos2, 16'h0000);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
